// File: rtl/con4_pkg.sv
// Shared constants, cell encodings and FSM/direction types for the connect-four win scanner.
package con4_pkg;

    localparam logic [2:0] ROWS    = 3'd6;
    localparam logic [2:0] COLS    = 3'd7;
    localparam logic [5:0] CELLS   = 6'd42;

    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] P1      = 2'b01;
    localparam logic [1:0] P2      = 2'b10;

    localparam logic [2:0] RUN_LEN = 3'd4;
    localparam logic [1:0] MAX_K   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        POS,
        NEG,
        NXT_DIR,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D1,
        DIR_D2
    } dir_e;

    // (drow, dcol) per direction, indexed by dir_e
    localparam logic signed [1:0] DROW [4] = '{2'sb00, 2'sb01, 2'sb01, 2'sb01};
    localparam logic signed [1:0] DCOL [4] = '{2'sb01, 2'sb00, 2'sb01, 2'sb11};

endpackage

// File: rtl/con4_win_scanner_if.sv
// Request/result and board-read signals of the win scanner; clk/rst stay outside.
interface con4_win_scanner_if;

    logic       start;
    logic [1:0] player;
    logic [2:0] last_row;
    logic [2:0] last_col;
    logic       clear_game;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy;
    logic       done;
    logic       win;
    logic       draw;
    logic       err;

    modport master (
        output start, player, last_row, last_col, clear_game, rd_data,
        input  rd_addr, busy, done, win, draw, err
    );

    modport slave (
        input  start, player, last_row, last_col, clear_game, rd_data,
        output rd_addr, busy, done, win, draw, err
    );

endinterface

// File: rtl/con4_step_addr.sv
// Candidate cell at distance k from (row, col) along +/- dir: board index and bounds flag.
module con4_step_addr
    import con4_pkg::*;
(
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  dir_e       dir,
    input  logic [1:0] k,
    input  logic       sign,
    output logic [5:0] addr,
    output logic       in_bounds
);

    logic signed [4:0] dr, dc, kk, r, c;

    always_comb begin
        dr = {{3{DROW[dir][1]}}, DROW[dir]};
        dc = {{3{DCOL[dir][1]}}, DCOL[dir]};
        kk = {3'b000, k};
        r  = $signed({2'b00, row}) + (sign ? -(dr * kk) : (dr * kk));
        c  = $signed({2'b00, col}) + (sign ? -(dc * kk) : (dc * kk));
        in_bounds = (r >= 5'sd0) && (r < $signed({2'b00, ROWS})) &&
                    (c >= 5'sd0) && (c < $signed({2'b00, COLS}));
        addr = {3'b000, r[2:0]} * 6'd7 + {3'b000, c[2:0]};
    end

endmodule

// File: rtl/con4_win_scanner.sv
// Walks the four lines through the last-placed piece, one board read per cycle,
// and reports win / draw / invalid-request with a one-cycle done pulse.
module con4_win_scanner
    import con4_pkg::*;
(
    input  logic clk,
    input  logic rst,
    con4_win_scanner_if.slave bus
);

    state_e     state, state_n;
    dir_e       dir_q, dir_n;
    logic [1:0] k_q, k_n;
    logic [2:0] count_q, count_n, count_inc;
    logic [1:0] player_q;
    logic [2:0] row_q, col_q;
    logic [5:0] move_cnt;
    logic       win_q, win_n, draw_q, draw_n, err_q, err_n;
    logic       accept, req_ok, hit, in_bounds, walking;
    logic [5:0] cand_addr;

    assign req_ok = ((bus.player == P1) || (bus.player == P2)) &&
                    (bus.last_row < ROWS) && (bus.last_col < COLS);

    con4_step_addr u_step (
        .row       (row_q),
        .col       (col_q),
        .dir       (dir_q),
        .k         (k_q),
        .sign      (state == NEG),
        .addr      (cand_addr),
        .in_bounds (in_bounds)
    );

    assign walking   = (state == POS) || (state == NEG);
    assign hit       = in_bounds && (bus.rd_data == player_q);
    assign count_inc = count_q + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        k_n     = k_q;
        count_n = count_q;
        win_n   = win_q;
        draw_n  = draw_q;
        err_n   = err_q;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    win_n   = 1'b0;
                    draw_n  = 1'b0;
                    err_n   = !req_ok;
                    dir_n   = DIR_H;
                    k_n     = 2'd1;
                    count_n = 3'd1;
                    state_n = req_ok ? POS : FIN;
                end
            end
            POS, NEG: begin
                // A miss, an off-board cell or the third step ends this half-walk
                if (hit) begin
                    count_n = count_inc;
                    if (count_inc == RUN_LEN) begin
                        win_n   = 1'b1;
                        state_n = FIN;
                    end else if (k_q == MAX_K) begin
                        k_n     = 2'd1;
                        state_n = (state == POS) ? NEG : NXT_DIR;
                    end else begin
                        k_n = k_q + 2'd1;
                    end
                end else begin
                    k_n     = 2'd1;
                    state_n = (state == POS) ? NEG : NXT_DIR;
                end
            end
            NXT_DIR: begin
                if (dir_q == DIR_D2) begin
                    draw_n  = (move_cnt == CELLS);
                    state_n = FIN;
                end else begin
                    dir_n   = dir_e'(dir_q + 2'd1);
                    k_n     = 2'd1;
                    count_n = 3'd1;
                    state_n = POS;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q    <= DIR_H;
            k_q      <= '0;
            count_q  <= '0;
            win_q    <= 1'b0;
            draw_q   <= 1'b0;
            err_q    <= 1'b0;
            player_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            dir_q   <= dir_n;
            k_q     <= k_n;
            count_q <= count_n;
            win_q   <= win_n;
            draw_q  <= draw_n;
            err_q   <= err_n;
            if (accept) begin
                player_q <= bus.player;
                row_q    <= bus.last_row;
                col_q    <= bus.last_col;
            end
        end
    end

    // Clear wins over increment, but a valid start in the same cycle still counts as move 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt <= '0;
        end else if (bus.clear_game) begin
            move_cnt <= (accept && req_ok) ? 6'd1 : '0;
        end else if (accept && req_ok && (move_cnt != CELLS)) begin
            move_cnt <= move_cnt + 6'd1;
        end
    end

    assign bus.rd_addr = (walking && in_bounds) ? cand_addr : '0;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == FIN);
    assign bus.win     = win_q;
    assign bus.draw    = draw_q;
    assign bus.err     = err_q;

endmodule
